// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder around one full_adder slice with a registered carry
//   full_adder  : in1, in2, cin -> sum, count (carry-out)
//   serial_adder: sys_clk, sys_rst (sync, active-high), start, in1[W], in2[W], cin
//                 -> busy, done (1-cycle pulse), sum[W], count (carry-out)
module full_adder (
  input  logic in1,
  input  logic in2,
  input  logic cin,
  output logic sum,
  output logic count
);
  assign sum   = in1 ^ in2 ^ cin;
  assign count = (in1 & in2) | (cin & (in1 ^ in2));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             count
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_sum, w_acc_next;
  logic [CW-1:0] r_cnt;
  logic r_carry, r_count, r_done, w_fa_sum, w_fa_count, w_last;
  full_adder u_fa (
    .in1  (r_a[0]),
    .in2  (r_b[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .count(w_fa_count)
  );
  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_one
      assign w_acc_next = w_fa_sum;
    end else begin : g_many
      assign w_acc_next = {w_fa_sum, r_acc[WIDTH-1:1]};
    end
  endgenerate
  assign w_last = r_cnt == LAST;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == IDLE ? (start ? RUN : IDLE) : (w_last ? IDLE : RUN);
  end
  always_comb begin
    busy = r_state == RUN;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_count <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE && start) begin
        r_a     <= in1;
        r_b     <= in2;
        r_carry <= cin;
        r_cnt   <= '0;
        r_acc   <= '0;
      end else if (r_state == RUN) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_acc   <= w_acc_next;
        r_carry <= w_fa_count;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          r_sum   <= w_acc_next;
          r_count <= w_fa_count;
          r_done  <= 1'b1;
        end
      end
    end
  end
  assign done  = r_done;
  assign sum   = r_sum;
  assign count = r_count;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst;
  logic start, cin, busy, done, count;
  logic [7:0] in1, in2, sum;
  logic s1_start, s1_in1, s1_in2, s1_cin, s1_busy, s1_done, s1_sum, s1_count;
  int total = 0;
  int fails = 0;
  logic seen;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .sys_clk(clk), .sys_rst(rst), .start(start), .in1(in1), .in2(in2), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .count(count)
  );
  serial_adder #(.WIDTH(1)) dut1 (
    .sys_clk(clk), .sys_rst(rst), .start(s1_start), .in1(s1_in1), .in2(s1_in2), .cin(s1_cin),
    .busy(s1_busy), .done(s1_done), .sum(s1_sum), .count(s1_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec, input string tag);
    int n;
    in1 = a; in2 = b; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_count"}, count, ec);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; cin = 1'b0;
    s1_start = 1'b0; s1_in1 = 1'b0; s1_in2 = 1'b0; s1_cin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_count", count, 0);
    chk("rst1_busy", s1_busy, 0);
    chk("rst1_sum", s1_sum, 0);
    // 0x5A + 0x3C: busy for 8 cycles, done after E8
    in1 = 8'h5A; in2 = 8'h3C; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t1_busy_e0", busy, 1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("t1_busy_run", busy, 1);
      chk("t1_done_early", done, 0);
    end
    @(negedge clk);
    chk("t1_done", done, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_sum", sum, 8'h96);
    chk("t1_count", count, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_sum_hold", sum, 8'h96);
    // new start: old result held until the new completion
    in1 = 8'h0F; in2 = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_sum_held", sum, 8'h96);
    repeat (4) @(negedge clk);
    chk("t5_done", done, 1);
    chk("t5_sum", sum, 8'h10);
    chk("t5_count", count, 0);
    // carry propagation
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t2a");
    run_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "t2b");
    // start held high: one result every 9 cycles, operand changes while busy ignored
    @(negedge clk);
    in1 = 8'h10; in2 = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      in1 = 8'hFF; in2 = 8'hFF;
      repeat (7) @(negedge clk);
      chk("t3_no_early_done", done, 0);
      in1 = 8'h10; in2 = 8'h20;
      @(negedge clk);
      chk("t3_done", done, 1);
      chk("t3_sum", sum, 8'h30);
      chk("t3_count", count, 0);
      if (r == 0) begin
        @(negedge clk);
        chk("t3_restart_busy", busy, 1);
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk("t3_idle", busy, 0);
    // reset mid-run
    in1 = 8'h80; in2 = 8'h80; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_sum", sum, 0);
    chk("t4_count", count, 0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | done;
    end
    chk("t4_no_done", seen, 0);
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "t4b");
    // WIDTH=1
    s1_in1 = 1'b1; s1_in2 = 1'b1; s1_cin = 1'b1; s1_start = 1'b1;
    @(negedge clk);
    s1_start = 1'b0;
    chk("w1_busy", s1_busy, 1);
    chk("w1_done_early", s1_done, 0);
    @(negedge clk);
    chk("w1_done", s1_done, 1);
    chk("w1_busy_end", s1_busy, 0);
    chk("w1_sum", s1_sum, 1);
    chk("w1_count", s1_count, 1);
    @(negedge clk);
    chk("w1_done_pulse", s1_done, 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
